vga_rect_fb: RTL
================

Name: vga_rect_fb

Overview:
- Downscaled frame buffer that sits directly upstream of the VGA timing controller.
- Read side: takes the controller's packed pixel coordinate {y[31:16], x[15:0]} and returns a 9-bit RGB333 word ({r,g,b} = q[8:6], q[5:3], q[2:0]).
- Write side: a rectangle-fill engine that accepts draw commands from game/keyboard logic (piano key highlight, background clear) and writes one pixel per clock into block RAM.

Parameters:
- FB_W, 160, frame buffer width in pixels.
- FB_H, 120, frame buffer height in pixels.
- SCALE_SHIFT, 2, right shift from screen coordinate to frame buffer coordinate (640x480 maps to 160x120).
- COLOR_W, 9, pixel width (RGB333).

Ports:
- clk  in  1  pixel clock, same clock as the VGA controller.
- rst  in  1  reset, asynchronous, active-high; clock clk.
- addr  in  32  screen coordinate {y, x}, 16 bits each.
- q  out  COLOR_W  pixel data for addr, registered.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  1  0 = fill rectangle, 1 = clear whole buffer.
- cmd_x0  in  8  rectangle left, in frame buffer coordinates.
- cmd_y0  in  8  rectangle top.
- cmd_x1  in  8  rectangle right, inclusive.
- cmd_y1  in  8  rectangle bottom, inclusive.
- cmd_color  in  COLOR_W  fill colour.
- busy  out  1  fill in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset values: q=0, cmd_ready=1, busy=0, done=0, state IDLE.
  - RAM contents are not cleared by reset; software issues a clear command.
- Read path:
  - fx = addr[15:0] >> SCALE_SHIFT, fy = addr[31:16] >> SCALE_SHIFT.
  - If fx<FB_W and fy<FB_H, then q <= mem[fy*FB_W+fx] at the next clk edge, otherwise q <= 0.
  - Latency is exactly 1 cycle. The resulting one-pixel horizontal lag is accepted.
- Memory: FB_W*FB_H words x COLOR_W bits, index width 15. One read port and one write port.
  - Read and write to the same index in the same cycle returns the old data (read-before-write).
- State machine: IDLE, FILL, DONE.
  - IDLE: cmd_ready=1. On accept, latch the command.
    - op=1: bounds become (0,0)-(FB_W-1,FB_H-1).
    - op=0: x1c = min(x1, FB_W-1), y1c = min(y1, FB_H-1).
    - If x0>x1c, y0>y1c, x0>=FB_W or y0>=FB_H, go to DONE with no writes. Otherwise go to FILL with cx=x0, cy=y0.
  - FILL: busy=1, cmd_ready=0. Each cycle write cmd_color at (cx,cy).
    - If cx==x1c: cx<=x0 and cy<=cy+1, otherwise cx<=cx+1.
    - After writing (x1c,y1c), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0, then IDLE.
- Timing: accept at edge T, first write at edge T+1, last write at edge T+W*H, done high during the cycle after edge T+W*H+1, cmd_ready high again one cycle later.
  - Degenerate command: done high during the cycle after edge T+1.
- cmd_valid while not ready is ignored; nothing is queued and inputs are not sampled.
- The read path is independent of the engine; reads are never stalled.
- Reset mid-fill: abort immediately into IDLE. Pixels already written remain; no done pulse.

Test Plan:
- Release reset -> cmd_ready=1, busy=0, done=0, q=0 on the first edge.
- Clear with colour 9'h1FF, accepted at T -> busy for 19200 cycles, done pulse once. Reading addr {16'd479,16'd639} then gives q=9'h1FF one cycle later; addr {16'd0,16'd640} gives q=0 (out of range).
- Fill (10,20)-(12,21), colour 9'h1C0, after the clear -> exactly 6 writes, done after edge T+7.
  - addr {16'd80,16'd40} -> 1C0; {16'd87,16'd51} -> 1C0.
  - {16'd80,16'd52} -> 1FF; {16'd88,16'd40} -> 1FF.
- Degenerate x0=5, x1=4 -> no RAM change, done pulse after edge T+1. Clipping x0=158, x1=200, y0=y1=0 -> writes only at x=158,159 (2 writes).
- cmd_valid held high during a fill with a different colour -> second command accepted only after done. Both rectangles are drawn in order, with no lost or duplicate writes.
- Assert rst at write 3 of a 6-pixel fill -> cmd_ready=1 and no done. The first 3 pixels are new colour; the remaining 3 are unchanged.

Source files
------------

// File: rtl/vga_rect_fb.sv
// rtl/vga_rect_fb.sv - downscaled RGB333 frame buffer with a rectangle-fill write engine
module vga_rect_fb #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int COLOR_W     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  output logic [COLOR_W-1:0] q,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [7:0]         cmd_x0,
  input  logic [7:0]         cmd_y0,
  input  logic [7:0]         cmd_x1,
  input  logic [7:0]         cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               busy,
  output logic               done
);

  localparam int         IDX_W = 15;
  localparam int         DEPTH = FB_W * FB_H;
  localparam logic [7:0] X_MAX = 8'(FB_W - 1);
  localparam logic [7:0] Y_MAX = 8'(FB_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  logic [COLOR_W-1:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic [7:0]         cx_q, cx_d, cy_q, cy_d;
  logic [7:0]         x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               done_q;

  logic [15:0]        fx, fy;
  logic               rd_in_range;
  logic [IDX_W-1:0]   rd_idx, wr_idx;
  logic               wr_en;

  assign fx          = addr[15:0] >> SCALE_SHIFT;
  assign fy          = addr[31:16] >> SCALE_SHIFT;
  assign rd_in_range = (fx < 16'(FB_W)) && (fy < 16'(FB_H));
  assign rd_idx      = IDX_W'(fy) * IDX_W'(FB_W) + IDX_W'(fx);
  assign wr_idx      = IDX_W'(cy_q) * IDX_W'(FB_W) + IDX_W'(cx_q);
  assign wr_en       = (state_q == FILL);

  // done is registered, so it trails the DONE state by a cycle; ready waits it out
  assign cmd_ready = (state_q == IDLE) && !done_q;
  assign busy      = (state_q == FILL);
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= color_q;
  end

  // Non-blocking write above makes a same-index read return the old word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              q <= '0;
    else if (rd_in_range) q <= mem[rd_idx];
    else                  q <= '0;
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          x0_d    = cmd_op ? 8'd0 : cmd_x0;
          y0_d    = cmd_op ? 8'd0 : cmd_y0;
          x1_d    = (cmd_op || cmd_x1 > X_MAX) ? X_MAX : cmd_x1;
          y1_d    = (cmd_op || cmd_y1 > Y_MAX) ? Y_MAX : cmd_y1;
          color_d = cmd_color;
          cx_d    = x0_d;
          cy_d    = y0_d;
          if (x0_d > x1_d || y0_d > y1_d || x0_d > X_MAX || y0_d > Y_MAX)
            state_d = DONE;
          else
            state_d = FILL;
        end
      end
      FILL: begin
        if (cx_q == x1_q) begin
          if (cy_q == y1_q) begin
            state_d = DONE;
          end else begin
            cx_d = x0_q;
            cy_d = cy_q + 8'd1;
          end
        end else begin
          cx_d = cx_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      done_q  <= (state_q == DONE);
    end
  end

endmodule
